// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared constants and hex font for the seven-segment controller
package seven_seg_pkg;

  // Active-low digit selects; bit0 drives the rightmost digit
  localparam logic [3:0] AN_OFF = 4'b1111;
  localparam logic [3:0] AN_D0  = 4'b1110;
  localparam logic [3:0] AN_D1  = 4'b1101;
  localparam logic [3:0] AN_D2  = 4'b1011;
  localparam logic [3:0] AN_D3  = 4'b0111;

  // All cathodes released
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns; entry n is the glyph for hex digit n
  localparam logic [15:0][6:0] HEX_FONT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [3:0] anode_for(input logic [1:0] idx);
    case (idx)
      2'd0:    return AN_D0;
      2'd1:    return AN_D1;
      2'd2:    return AN_D2;
      default: return AN_D3;
    endcase
  endfunction

endpackage

// File: rtl/seven_seg_display_ctrl_hex_to_seg.sv
// rtl/seven_seg_display_ctrl_hex_to_seg.sv - combinational nibble to active-low segment decode
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Straight table lookup into the shared font
  assign seg = HEX_FONT[nibble];

endmodule

// File: rtl/seven_seg_display_ctrl.sv
// rtl/seven_seg_display_ctrl.sv - 4-digit multiplexed seven-segment driver with tear-free value update
module seven_seg_display_ctrl
  import seven_seg_pkg::*;
#(
  parameter int          DIV_BITS    = 16,
  parameter logic [15:0] RESET_VALUE = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] load_value,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [3:0]  digit_en,
  input  logic        lz_blank,
  input  logic [2:0]  brightness,
  output logic [3:0]  anode,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  logic [DIV_BITS-1:0] slot_cnt;
  logic [1:0]          scan_idx;
  logic [15:0]         pending_value;
  logic [15:0]         shown_value;
  logic                pending_full;

  logic                frame_edge;
  logic                load_fire;
  logic [3:0]          cur_nibble;
  logic [6:0]          cur_seg;
  logic [2:0]          top3;
  logic [3:0]          lz_mask;
  logic                digit_lit;

  // Last clock of the slot for digit 3: the only point where a new value may take effect
  assign frame_edge = (&slot_cnt) && (scan_idx == 2'd3);
  assign load_ready = !pending_full;
  assign load_fire  = load_valid && load_ready;
  assign dp         = 1'b1;

  assign cur_nibble = shown_value[{scan_idx, 2'b00} +: 4];
  assign top3       = slot_cnt[DIV_BITS-1 -: 3];

  hex_to_seg u_hex_to_seg (
    .nibble (cur_nibble),
    .seg    (cur_seg)
  );

  // Leading-zero mask: a digit is blankable when it and every digit to its left are zero
  always_comb begin
    lz_mask    = 4'b0000;
    lz_mask[3] = (shown_value[15:12] == 4'h0);
    lz_mask[2] = lz_mask[3] && (shown_value[11:8] == 4'h0);
    lz_mask[1] = lz_mask[2] && (shown_value[7:4] == 4'h0);
  end

  // Counter 0 is a guard cycle so the previous digit's cathodes never ghost onto the next anode
  always_comb begin
    digit_lit = (top3 <= brightness) && (slot_cnt != '0) && digit_en[scan_idx]
                && !(lz_blank && lz_mask[scan_idx]);
  end

  // Slot timer and scan index; the index steps each time the slot counter wraps
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slot_cnt <= '0;
      scan_idx <= 2'd0;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
      if (&slot_cnt) begin
        scan_idx <= scan_idx + 2'd1;
      end
    end
  end

  // Double buffer: capture into pending, promote to shown only at a frame edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending_value <= 16'h0000;
      pending_full  <= 1'b0;
      shown_value   <= RESET_VALUE;
    end else begin
      if (load_fire) begin
        pending_value <= load_value;
        pending_full  <= 1'b1;
      end else if (frame_edge && pending_full) begin
        shown_value  <= pending_value;
        pending_full <= 1'b0;
      end
    end
  end

  // Registered pin drive and frame marker, one clock behind the scan state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      anode       <= AN_OFF;
      seg         <= SEG_BLANK;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_edge;
      if (digit_lit) begin
        anode <= anode_for(scan_idx);
        seg   <= cur_seg;
      end else begin
        anode <= AN_OFF;
        seg   <= SEG_BLANK;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_display_ctrl.sv
// tb/tb_seven_seg_display_ctrl.sv - directed table-driven bench for seven_seg_display_ctrl
module tb_seven_seg_display_ctrl;

  logic        clock;
  logic        reset;
  logic [15:0] load_value;
  logic        load_valid;
  logic        load_ready;
  logic [3:0]  digit_en;
  logic        lz_blank;
  logic [2:0]  brightness;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  int n_checks;
  int n_fail;

  seven_seg_display_ctrl #(
    .DIV_BITS    (4),
    .RESET_VALUE (16'h0000)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .load_value  (load_value),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .digit_en    (digit_en),
    .lz_blank    (lz_blank),
    .brightness  (brightness),
    .anode       (anode),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] value;
    logic        lz;
    logic [3:0]  en;
    logic [2:0]  br;
    logic [27:0] segs;
    logic [3:0]  lit;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_frame_start(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!frame_start && n < 300);
  endtask

  // Entered at a negedge where frame_start is high; checks one whole frame of pin activity
  task automatic check_frame(input logic [27:0] segs, input logic [3:0] lit_mask);
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_fs;
    logic       lit;
    for (int idx = 0; idx < 4; idx++) begin
      for (int c = 0; c < 16; c++) begin
        @(negedge clock);
        lit     = ((c / 2) <= int'(brightness)) && (c != 0) && digit_en[idx] && lit_mask[idx];
        exp_an  = lit ? ~(4'b0001 << idx) : 4'b1111;
        exp_seg = lit ? segs[idx*7 +: 7] : 7'h7F;
        exp_fs  = (idx == 3) && (c == 15);
        chk($sformatf("frame d%0d c%0d {anode,seg,fs}", idx, c),
            {20'd0, anode, seg, frame_start}, {20'd0, exp_an, exp_seg, exp_fs});
      end
    end
  endtask

  // Mid-frame load; display must hold old glyphs until the value goes live at the frame edge
  task automatic apply_value(input logic [15:0] v, input logic [27:0] prev_segs);
    int  n;
    logic torn;
    torn = 1'b0;
    n = 0;
    while (!load_ready && n < 300) begin
      @(negedge clock);
      n++;
    end
    load_value = v;
    load_valid = 1'b1;
    @(negedge clock);
    load_valid = 1'b0;
    load_value = 16'hDEAD;
    chk("load_ready drops after capture", {31'd0, load_ready}, 32'd0);
    n = 0;
    while (!load_ready && n < 300) begin
      if (seg != 7'h7F && seg != prev_segs[6:0] && seg != prev_segs[13:7] &&
          seg != prev_segs[20:14] && seg != prev_segs[27:21])
        torn = 1'b1;
      @(negedge clock);
      n++;
    end
    chk("load_ready returns", {31'd0, load_ready}, 32'd1);
    chk("no tearing before frame edge", {31'd0, torn}, 32'd0);
    chk("load_ready returns with frame_start", {31'd0, frame_start}, 32'd1);
  endtask

  initial begin
    int   n;
    logic [27:0] prev;
    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{16'h0000, 1'b0, 4'hF, 3'd7, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111};
    vecs[1] = '{16'h12AF, 1'b0, 4'hF, 3'd7, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1111};
    vecs[2] = '{16'h0070, 1'b1, 4'hF, 3'd7, {7'h7F, 7'h7F, 7'h78, 7'h40}, 4'b0011};
    vecs[3] = '{16'h0000, 1'b1, 4'hF, 3'd7, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0001};
    vecs[4] = '{16'h12AF, 1'b0, 4'hF, 3'd0, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1111};
    vecs[5] = '{16'h12AF, 1'b0, 4'h5, 3'd3, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1111};
    vecs[6] = '{16'h8C3D, 1'b1, 4'hF, 3'd7, {7'h00, 7'h46, 7'h30, 7'h21}, 4'b1111};

    reset      = 1'b0;
    load_value = 16'h0000;
    load_valid = 1'b0;
    digit_en   = 4'hF;
    lz_blank   = 1'b0;
    brightness = 3'd7;

    repeat (3) @(negedge clock);
    chk("reset anode", {28'd0, anode}, 32'hF);
    chk("reset seg", {25'd0, seg}, 32'h7F);
    chk("reset dp", {31'd0, dp}, 32'd1);
    chk("reset frame_start", {31'd0, frame_start}, 32'd0);
    chk("reset load_ready", {31'd0, load_ready}, 32'd1);

    reset = 1'b1;
    wait_frame_start(n);
    chk("first frame_start cycle", n, 64);
    check_frame(vecs[0].segs, vecs[0].lit);
    check_frame(vecs[0].segs, vecs[0].lit);

    prev = vecs[0].segs;
    for (int i = 0; i < 7; i++) begin
      repeat (20) @(negedge clock);
      lz_blank   = vecs[i].lz;
      digit_en   = vecs[i].en;
      brightness = vecs[i].br;
      apply_value(vecs[i].value, prev);
      check_frame(vecs[i].segs, vecs[i].lit);
      prev = vecs[i].segs;
    end

    // Offer held across a busy period: the second value lands one frame after the first
    lz_blank   = 1'b0;
    digit_en   = 4'hF;
    brightness = 3'd7;
    repeat (10) @(negedge clock);
    load_value = 16'h1111;
    load_valid = 1'b1;
    @(negedge clock);
    chk("held: first capture", {31'd0, load_ready}, 32'd0);
    load_value = 16'h2222;
    n = 0;
    while (!load_ready && n < 300) begin
      @(negedge clock);
      n++;
    end
    chk("held: frame_start at ready", {31'd0, frame_start}, 32'd1);
    @(negedge clock);
    load_valid = 1'b0;
    chk("held: second capture", {31'd0, load_ready}, 32'd0);
    @(negedge clock);
    chk("held: first value shown {anode,seg}", {21'd0, anode, seg}, {21'd0, 4'b1110, 7'h79});
    wait_frame_start(n);
    chk("held: frame_start found", {31'd0, frame_start}, 32'd1);
    check_frame({7'h24, 7'h24, 7'h24, 7'h24}, 4'b1111);

    // Reset while a value is pending and digit 2 is being scanned
    repeat (5) @(negedge clock);
    load_value = 16'h5555;
    load_valid = 1'b1;
    @(negedge clock);
    load_valid = 1'b0;
    n = 0;
    while (anode != 4'b1011 && n < 300) begin
      @(negedge clock);
      n++;
    end
    chk("pending before reset", {31'd0, load_ready}, 32'd0);
    chk("slot 2 reached", {28'd0, anode}, 32'hB);
    #2 reset = 1'b0;
    #1;
    chk("async reset anode", {28'd0, anode}, 32'hF);
    chk("async reset seg", {25'd0, seg}, 32'h7F);
    chk("async reset load_ready", {31'd0, load_ready}, 32'd1);
    @(negedge clock);
    reset = 1'b1;
    wait_frame_start(n);
    chk("frame_start after re-reset", n, 64);
    check_frame(vecs[0].segs, 4'b1111);
    check_frame(vecs[0].segs, 4'b1111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
